boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Program-download front end that sits directly upstream of the core's instruction memory and pc.
- Consumes a byte stream from a UART receiver and assembles little-endian 32-bit instruction words.
- Writes each word into inst_rom and holds the pipeline while a load is in progress.
- On a valid frame it releases the core to start fetching at address 0; on a malformed frame it flags an error and keeps the core held.

Parameters:
- ROM_AW, 12, instruction ROM depth in words as log2; maximum frame length is 2^ROM_AW words.
- TIMEOUT, 1000000, maximum idle cycles allowed between bytes inside a frame.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- i_Clk  in  1  system clock.
- i_reset  in  1  asynchronous active-low reset.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new byte.
- i_rx_data  in  8  received byte.
- o_rom_we  out  1  one-cycle write strobe to inst_rom.
- o_rom_addr  out  32  byte address of the word being written (word_index*4).
- o_rom_data  out  32  assembled instruction word.
- o_cpu_hold  out  1  1 = keep pc and pipeline held/flushed.
- o_done  out  1  level; last frame loaded and checksum matched.
- o_err  out  1  level; last frame failed.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; o_rom_we=0, o_rom_addr=0, o_rom_data=0, o_cpu_hold=1, o_done=0, o_err=0.
  - All counters and the checksum register clear.
- Frame format: HDR_BYTE, LEN_LO, LEN_HI, then N*4 payload bytes (little-endian per word), then CSUM.
  - N = {LEN_HI, LEN_LO}.
  - CSUM = sum of payload bytes mod 256; header and length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. State advances only on cycles where i_rx_valid=1.
- IDLE / DONE / ERR:
  - A byte equal to HDR_BYTE moves to LEN_LO, clears o_done and o_err, sets o_cpu_hold=1, and clears the word index, byte lane and checksum.
  - Any other byte is ignored.
- LEN_LO: latch the low length byte, then go to LEN_HI.
- LEN_HI: latch the high length byte.
  - If N > 2^ROM_AW, go to ERR.
  - If N = 0, go to CSUM.
  - Otherwise go to DATA.
- DATA:
  - Each byte is shifted into lane [8*k+7:8*k], k=0..3, and added to the checksum.
  - On lane 3, the cycle after that byte: o_rom_we=1 for exactly 1 cycle, o_rom_data = assembled word, o_rom_addr = index<<2. The index then increments.
  - After word N-1 is written, go to CSUM.
  - o_rom_addr and o_rom_data hold their values between strobes.
- CSUM:
  - Byte equals checksum: go to DONE, o_done=1, o_cpu_hold=0 (registered, so it falls 1 cycle after the byte).
  - Byte differs: go to ERR, o_err=1, o_cpu_hold stays 1.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, a gap counter increments every cycle without i_rx_valid.
  - Reaching TIMEOUT forces ERR, o_err=1; a partially assembled word is discarded and not written.
  - The counter clears on every accepted byte.
- Words already written before an error remain in ROM; o_cpu_hold stays 1 regardless.
- A HDR_BYTE value inside DATA or LEN is treated as data; there is no resync mid-frame.
- i_rx_valid on the same cycle as a timeout expiry: the byte wins and the counter clears.
- o_rom_we never asserts outside DATA.
- Asynchronous reset mid-frame returns to IDLE with o_cpu_hold=1; no partial write is issued.
- The core executes only between DONE and the next header.

Decomposition:
- Shared defines file (existing `define style) gains:
  - `LoaderStateBus [2:0] and the seven state codes.
  - `BOOT_HDR.
  - Reuse of `InstAddrBus and `InstDataBus for o_rom_addr and o_rom_data.
- One natural sub-module: boot_word_asm (byte-lane shifter, lane counter, checksum accumulator, word-ready strobe).
- FSM, length check and timeout stay in boot_loader.

Test Plan:
- Frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0xB6 -> writes (addr 0x0, 0x00000013) and (addr 0x4, 0x00100093); each o_rom_we is 1 cycle, 1 cycle after the lane-3 byte; o_done=1; o_cpu_hold falls 1 cycle after CSUM.
- Same frame with CSUM=0xB7 -> both writes occur; o_err=1, o_done=0, o_cpu_hold=1. Resend the correct frame -> o_err clears on the header, o_done=1.
- A5 00 00 00 -> no writes, o_done=1. A5 00 00 05 -> o_err=1.
- ROM_AW=2 with A5 05 00 -> ERR immediately after LEN_HI; no o_rom_we.
- TIMEOUT=16: send A5 01 00 11 22 then silence -> o_err=1 exactly 16 cycles after the 0x22 byte, no write. A byte at cycle 15 -> the counter restarts.
- Pull i_reset low during DATA after 2 bytes -> all outputs at reset values immediately. Stray bytes 0x00/0xFF in IDLE -> ignored, o_cpu_hold stays 1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART program loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam logic [7:0] BOOT_HDR    = 8'hA5;
  localparam int         INST_ADDR_W = 32;
  localparam int         INST_DATA_W = 32;

  // Word index to byte address in the instruction ROM.
  function automatic logic [INST_ADDR_W-1:0] wordAddr(input logic [16:0] idx);
    return {13'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler with running payload checksum.
module boot_word_asm
  import boot_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   byteValid_i,
  input  logic [7:0]             byte_i,
  output logic                   lane3_o,
  output logic [INST_DATA_W-1:0] word_o,
  output logic                   wordWe_o,
  output logic [7:0]             csum_o
);

  logic [1:0]             lane_q;
  logic [23:0]            shift_q;
  logic [INST_DATA_W-1:0] word_q;
  logic                   we_q;
  logic [7:0]             csum_q;

  // word_q only changes on a completed word so the ROM data bus stays stable between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= '0;
      we_q    <= 1'b0;
      csum_q  <= 8'd0;
    end else begin
      we_q <= 1'b0;
      if (clear_i) begin
        lane_q  <= 2'd0;
        shift_q <= 24'd0;
        csum_q  <= 8'd0;
      end else if (byteValid_i) begin
        csum_q <= csum_q + byte_i;
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0:    shift_q[7:0]   <= byte_i;
          2'd1:    shift_q[15:8]  <= byte_i;
          2'd2:    shift_q[23:16] <= byte_i;
          default: begin
            word_q <= {byte_i, shift_q};
            we_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign lane3_o  = (lane_q == 2'd3);
  assign word_o   = word_q;
  assign wordWe_o = we_q;
  assign csum_o   = csum_q;

endmodule

// File: rtl/boot_loader.sv
// Frame parser that loads instruction ROM from a UART byte stream and gates core start.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ROM_AW   = 12,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] HDR_BYTE = BOOT_HDR
) (
  input  logic                   i_Clk,
  input  logic                   i_reset,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  output logic                   o_rom_we,
  output logic [INST_ADDR_W-1:0] o_rom_addr,
  output logic [INST_DATA_W-1:0] o_rom_data,
  output logic                   o_cpu_hold,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int          GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ROM_AW);

  loader_state_e          state_q;
  logic [7:0]             lenLo_q;
  logic [15:0]            len_q;
  logic [16:0]            index_q;
  logic [GAP_W-1:0]       gap_q;
  logic [INST_ADDR_W-1:0] addr_q;
  logic                   done_q, err_q, hold_q;

  logic                   inFrame, hdrSeen, wordsDone, dataByte, csumByte, timeoutHit;
  logic                   asmLane3, asmWe;
  logic [INST_DATA_W-1:0] asmWord;
  logic [7:0]             asmCsum;
  logic [15:0]            lenNew;

  assign inFrame    = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
  assign hdrSeen    = i_rx_valid && (i_rx_data == HDR_BYTE) &&
                      (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign wordsDone  = (index_q == {1'b0, len_q});
  assign dataByte   = i_rx_valid && (state_q == ST_DATA) && !wordsDone;
  // A checksum byte that arrives in the strobe cycle of the last word is still judged.
  assign csumByte   = i_rx_valid && ((state_q == ST_CSUM) || ((state_q == ST_DATA) && wordsDone));
  assign timeoutHit = inFrame && !i_rx_valid && (gap_q == GAP_W'(TIMEOUT - 1));
  assign lenNew     = {i_rx_data, lenLo_q};

  boot_word_asm u_asm (
    .clk_i      (i_Clk),
    .rst_ni     (i_reset),
    .clear_i    (hdrSeen),
    .byteValid_i(dataByte),
    .byte_i     (i_rx_data),
    .lane3_o    (asmLane3),
    .word_o     (asmWord),
    .wordWe_o   (asmWe),
    .csum_o     (asmCsum)
  );

  always_ff @(posedge i_Clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      lenLo_q <= 8'd0;
      len_q   <= 16'd0;
      index_q <= 17'd0;
      gap_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      if (inFrame && !i_rx_valid) gap_q <= gap_q + GAP_W'(1);
      else                        gap_q <= '0;

      if (timeoutHit) begin
        state_q <= ST_ERR;
        err_q   <= 1'b1;
        hold_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (hdrSeen) begin
              state_q <= ST_LEN_LO;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              hold_q  <= 1'b1;
              index_q <= 17'd0;
            end
          end
          ST_LEN_LO: begin
            if (i_rx_valid) begin
              lenLo_q <= i_rx_data;
              state_q <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (i_rx_valid) begin
              len_q <= lenNew;
              if ({1'b0, lenNew} > MAX_WORDS) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end else if (lenNew == 16'd0) begin
                state_q <= ST_CSUM;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA, ST_CSUM: begin
            if (csumByte) begin
              if (i_rx_data == asmCsum) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
              end else begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end else if ((state_q == ST_DATA) && wordsDone) begin
              state_q <= ST_CSUM;
            end else if (dataByte && asmLane3) begin
              addr_q  <= wordAddr(index_q);
              index_q <= index_q + 17'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_rom_we   = asmWe;
  assign o_rom_addr = addr_q;
  assign o_rom_data = asmWord;
  assign o_cpu_hold = hold_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame bench for boot_loader against a frame-level reference model.
`timescale 1ns/1ps
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        romWe;
  logic [31:0] romAddr;
  logic [31:0] romData;
  logic        cpuHold;
  logic        done;
  logic        err;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic        prevWe = 1'b0;
  logic        mDone = 1'b0;
  logic        mErr  = 1'b0;

  always #5 clk = ~clk;

  boot_loader #(.ROM_AW(2), .TIMEOUT(16), .HDR_BYTE(8'hA5)) dut (
    .i_Clk     (clk),
    .i_reset   (rstN),
    .i_rx_valid(rxValid),
    .i_rx_data (rxData),
    .o_rom_we  (romWe),
    .o_rom_addr(romAddr),
    .o_rom_data(romData),
    .o_cpu_hold(cpuHold),
    .o_done    (done),
    .o_err     (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Every ROM write must match the next word the model predicted, and last one cycle.
  always @(negedge clk) begin
    if (romWe) begin
      checkOutput("we_width", 32'(prevWe), 32'd0);
      checkOutput("we_expected", 32'(expAddrQ.size() != 0), 32'd1);
      if (expAddrQ.size() != 0) begin
        checkOutput("rom_addr", romAddr, expAddrQ.pop_front());
        checkOutput("rom_data", romData, expDataQ.pop_front());
      end
    end
    prevWe = romWe;
  end

  // Called just after a falling edge; the byte is sampled on the following rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rxValid = 1'b1;
    rxData  = b;
    @(negedge clk);
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'(mDone));
    checkOutput({tag, "_err"},  32'(err),  32'(mErr));
    checkOutput({tag, "_hold"}, 32'(cpuHold), 32'(!mDone));
    checkOutput({tag, "_pending"}, 32'(expAddrQ.size()), 32'd0);
  endtask

  // Reference model: words are payload bytes packed little-endian; checksum is the byte sum.
  task automatic sendFrame(input logic [15:0] n, input logic [7:0] payload[$], input logic [7:0] csumDelta, input int maxGap);
    int unsigned sum = 0;
    applyStimulus(8'hA5, $urandom_range(0, maxGap));
    applyStimulus(n[7:0], $urandom_range(0, maxGap));
    applyStimulus(n[15:8], $urandom_range(0, maxGap));
    if (n > 16'd4) begin
      mDone = 1'b0;
      mErr  = 1'b1;
    end else begin
      for (int w = 0; w < int'(n); w++) begin
        expAddrQ.push_back(32'(w * 4));
        expDataQ.push_back(32'(payload[4*w]) + 32'(payload[4*w+1]) * 256 +
                           32'(payload[4*w+2]) * 65536 + 32'(payload[4*w+3]) * 16777216);
      end
      for (int i = 0; i < 4 * int'(n); i++) begin
        sum += payload[i];
        applyStimulus(payload[i], $urandom_range(0, maxGap));
      end
      applyStimulus(8'(sum % 256) + csumDelta, 0);
      mDone = (csumDelta == 8'd0);
      mErr  = (csumDelta != 8'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  // Test-plan frame sent back to back, checking strobe timing and hold release.
  task automatic runPlanFrame(input logic [7:0] csum, input string tag);
    logic [7:0] p[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    applyStimulus(8'hA5, 0);
    checkOutput({tag, "_err_cleared"}, 32'(err), 32'd0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    expAddrQ.push_back(32'h0);  expDataQ.push_back(32'h00000013);
    expAddrQ.push_back(32'h4);  expDataQ.push_back(32'h00100093);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(p[i], 0);
      if (i % 4 == 3) begin
        checkOutput({tag, "_we_after_lane3"}, 32'(romWe), 32'd1);
        if (i == 3) begin
          @(negedge clk);
          checkOutput({tag, "_we_dropped"}, 32'(romWe), 32'd0);
        end
      end
    end
    checkOutput({tag, "_hold_before_csum"}, 32'(cpuHold), 32'd1);
    applyStimulus(csum, 0);
    mDone = (csum == 8'hB6);
    mErr  = (csum != 8'hB6);
    checkOutput({tag, "_hold_after_csum"}, 32'(cpuHold), 32'(csum != 8'hB6));
    @(negedge clk);
    checkStatus(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [15:0] n;
    rstN    = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_we",   32'(romWe),   32'd0);
    checkOutput("rst_addr", romAddr,      32'd0);
    checkOutput("rst_data", romData,      32'd0);
    checkOutput("rst_hold", 32'(cpuHold), 32'd1);
    checkOutput("rst_done", 32'(done),    32'd0);
    checkOutput("rst_err",  32'(err),     32'd0);
    rstN = 1'b1;
    @(negedge clk);

    applyStimulus(8'h00, 1);
    applyStimulus(8'hFF, 1);
    checkStatus("stray");

    runPlanFrame(8'hB6, "plan_ok");
    runPlanFrame(8'hB7, "plan_bad");
    runPlanFrame(8'hB6, "plan_resend");

    pl = {};
    sendFrame(16'd0, pl, 8'd0, 0);
    checkStatus("empty_ok");
    sendFrame(16'd0, pl, 8'd5, 0);
    checkStatus("empty_bad");

    applyStimulus(8'hA5, 0);
    applyStimulus(8'h05, 0);
    applyStimulus(8'h00, 0);
    mDone = 1'b0;
    mErr  = 1'b1;
    checkOutput("oversize_err_now", 32'(err), 32'd1);
    checkStatus("oversize");

    // Idle gap reaching the limit after 0x22 aborts the frame.
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    repeat (15) @(negedge clk);
    checkOutput("timeout_early", 32'(err), 32'd0);
    @(negedge clk);
    mDone = 1'b0;
    mErr  = 1'b1;
    checkOutput("timeout_hit", 32'(err), 32'd1);
    checkStatus("timeout");

    // Bytes just before and exactly on expiry keep the frame alive.
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 14);
    applyStimulus(8'h22, 15);
    applyStimulus(8'h33, 0);
    checkOutput("restart_no_err", 32'(err), 32'd0);
    expAddrQ.push_back(32'h0);
    expDataQ.push_back(32'h44332211);
    applyStimulus(8'h44, 0);
    checkOutput("restart_we", 32'(romWe), 32'd1);
    applyStimulus(8'hAA, 2);
    mDone = 1'b1;
    mErr  = 1'b0;
    checkStatus("restart");

    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(0, 7);
      logic [7:0] stray;
      repeat ($urandom_range(0, 2)) begin
        stray = 8'($urandom_range(0, 255));
        if (stray == 8'hA5) stray = 8'h5A;
        applyStimulus(stray, $urandom_range(0, 3));
      end
      checkOutput("rand_stray_hold", 32'(cpuHold), 32'(!mDone));
      n = (kind <= 5) ? 16'(kind) : ((kind == 6) ? 16'h0104 : 16'd4);
      pl = {};
      if (n <= 16'd4)
        for (int i = 0; i < 4 * int'(n); i++) pl.push_back(8'($urandom_range(0, 255)));
      sendFrame(n, pl, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, 6);
      checkStatus("rand");
    end

    runPlanFrame(8'hB6, "pre_reset");
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_we",   32'(romWe),   32'd0);
    checkOutput("midrst_addr", romAddr,      32'd0);
    checkOutput("midrst_data", romData,      32'd0);
    checkOutput("midrst_hold", 32'(cpuHold), 32'd1);
    checkOutput("midrst_done", 32'(done),    32'd0);
    checkOutput("midrst_err",  32'(err),     32'd0);
    @(negedge clk);
    rstN = 1'b1;
    mDone = 1'b0;
    mErr  = 1'b0;
    @(negedge clk);
    applyStimulus(8'h00, 1);
    applyStimulus(8'hFF, 1);
    checkStatus("post_reset_stray");
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(16'd1, pl, 8'd0, 3);
    checkStatus("post_reset_frame");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
